// File: rtl/gray2bin_sync.sv
// Receive-side Gray pointer synchronizer and decoder: multi-flop sync, binary decode, advance delta.
// Optional sticky multi-bit-change checker enabled by defining GRAY2BIN_SYNC_CHECK_EN.
module gray2bin_sync #(
  parameter int K           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] gray_in,
  output logic [K-1:0] gray_sync,
  output logic [K-1:0] bin_out,
  output logic [K-1:0] delta,
  output logic         bin_valid,
  output logic         gray_err
);

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] FILL_MAX = CW'(SYNC_STAGES + 1);

  logic [K-1:0]  sync_q [SYNC_STAGES];
  logic [K-1:0]  bin_dec;
  logic [CW-1:0] fill_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gray_sync = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_dec        = '0;
    bin_dec[K-1]   = gray_sync[K-1];
    for (int i = K - 2; i >= 0; i--) bin_dec[i] = bin_dec[i+1] ^ gray_sync[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out <= '0;
      delta   <= '0;
    end else begin
      bin_out <= bin_dec;
      delta   <= bin_dec - bin_out;
    end
  end

  // bin_valid rises on the same edge the fill counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt  <= '0;
      bin_valid <= 1'b0;
    end else begin
      if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + CW'(1);
      if (fill_cnt == FILL_MAX - CW'(1)) bin_valid <= 1'b1;
    end
  end

`ifdef GRAY2BIN_SYNC_CHECK_EN
  logic [K-1:0] gray_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_prev <= '0;
      gray_err  <= 1'b0;
    end else begin
      gray_prev <= gray_sync;
      if (bin_valid && ($countones(gray_sync ^ gray_prev) > 1)) gray_err <= 1'b1;
    end
  end
`else
  assign gray_err = 1'b0;
`endif

endmodule
